// File: rtl/sal_axi_traffic_gen_if.sv
// sal_axi_traffic_gen_if: AXI4 AW/W/B/AR/R bus between the traffic generator (master) and a slave
// Parameters ADDR_W/DATA_W/ID_W size the address, data and ID fields; awlen/arlen are 8 bits.
interface sal_axi_traffic_gen_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ID_W   = 4
);
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic              wvalid, wready, wlast;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic              rvalid, rready, rlast;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    modport master (
        output awvalid, awaddr, awid, awlen, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arid, arlen, input arready,
        input rvalid, rdata, rresp, rlast, output rready
    );

    modport slave (
        input awvalid, awaddr, awid, awlen, output awready,
        input wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arid, arlen, output arready,
        output rvalid, rdata, rresp, rlast, input rready
    );
endinterface

// File: rtl/sal_axi_traffic_gen.sv
// sal_axi_traffic_gen: AXI4 burst traffic generator with write, read and write-then-read-check modes
// Ports: clk; rst_n (asynchronous, active-high); start/mode/base_addr/stride/num_txn configure a run;
//        busy/done/err_cnt/resp_err report status; axi is the AXI master bus.
module sal_axi_traffic_gen #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int ID_W      = 4,
    parameter int BURST_LEN = 4,
    parameter int MAX_OUT   = 4,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     stride,
    input  logic [CNT_W-1:0]      num_txn,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt,
    output logic                  resp_err,
    sal_axi_traffic_gen_if.master axi
);
    typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;

    state_t            state;
    logic [1:0]        md;
    logic [ADDR_W-1:0] base, strd, a_addr, d_addr;
    logic [CNT_W-1:0]  num, k_cnt, d_k, b_cnt, last;
    logic [7:0]        d_j;
    logic [4:0]        out;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, r_end, a_ok, w_load, w_end;
    logic [31:0]       pat;
    logic [DATA_W-1:0] exp_d;

    assign busy       = state != IDLE;
    assign done       = state == FIN;
    assign axi.bready = busy;
    assign axi.rready = busy;
    assign axi.awlen  = 8'(BURST_LEN - 1);
    assign axi.arlen  = 8'(BURST_LEN - 1);
    assign axi.wstrb  = '1;

    assign aw_hs = axi.awvalid & axi.awready;
    assign w_hs  = axi.wvalid & axi.wready;
    assign b_hs  = axi.bvalid & axi.bready;
    assign ar_hs = axi.arvalid & axi.arready;
    assign r_hs  = axi.rvalid & axi.rready;
    assign r_end = r_hs & axi.rlast;
    assign last  = num - CNT_W'(1);
    assign w_end = d_j == 8'(BURST_LEN - 1);
    // Address channels raise valid only from an idle slot, so the outstanding count cannot overshoot.
    assign a_ok   = k_cnt < num && out < 5'(MAX_OUT);
    // A W burst may only be loaded once its own AW handshake is already counted in k_cnt.
    assign w_load = state == WR && (!axi.wvalid || axi.wready) && d_k < k_cnt;
    // d_k/d_j/d_addr track the data-side burst; the same pattern feeds W generation and R checking.
    assign pat   = {16'(d_k), d_j, 8'hA5} ^ 32'(d_addr);
    assign exp_d = {(DATA_W / 32){pat}};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            md          <= '0;
            base        <= '0;
            strd        <= '0;
            num         <= '0;
            a_addr      <= '0;
            d_addr      <= '0;
            k_cnt       <= '0;
            d_k         <= '0;
            b_cnt       <= '0;
            d_j         <= '0;
            out         <= '0;
            err_cnt     <= '0;
            resp_err    <= 1'b0;
            axi.awvalid <= 1'b0;
            axi.awaddr  <= '0;
            axi.awid    <= '0;
            axi.wvalid  <= 1'b0;
            axi.wdata   <= '0;
            axi.wlast   <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.araddr  <= '0;
            axi.arid    <= '0;
        end else begin
            k_cnt <= k_cnt + CNT_W'(aw_hs | ar_hs);
            out   <= out + 5'(aw_hs | ar_hs) - 5'(b_hs | r_end);
            if ((b_hs && axi.bresp != 2'b00) || (r_hs && axi.rresp != 2'b00))
                resp_err <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    md       <= mode;
                    base     <= base_addr;
                    strd     <= stride;
                    num      <= num_txn;
                    a_addr   <= base_addr;
                    d_addr   <= base_addr;
                    k_cnt    <= '0;
                    d_k      <= '0;
                    b_cnt    <= '0;
                    d_j      <= '0;
                    out      <= '0;
                    err_cnt  <= '0;
                    resp_err <= 1'b0;
                    state    <= (mode == 2'd3 || num_txn == '0) ? FIN : mode == 2'd1 ? RD : WR;
                end
                WR: begin
                    if (!axi.awvalid && a_ok) begin
                        axi.awvalid <= 1'b1;
                        axi.awaddr  <= a_addr;
                        axi.awid    <= k_cnt[ID_W-1:0];
                        a_addr      <= a_addr + strd;
                    end else if (aw_hs)
                        axi.awvalid <= 1'b0;
                    if (w_load) begin
                        axi.wvalid <= 1'b1;
                        axi.wdata  <= exp_d;
                        axi.wlast  <= w_end;
                        d_j        <= w_end ? 8'd0 : d_j + 8'd1;
                        if (w_end) begin
                            d_k    <= d_k + CNT_W'(1);
                            d_addr <= d_addr + strd;
                        end
                    end else if (w_hs)
                        axi.wvalid <= 1'b0;
                    if (b_hs) begin
                        b_cnt <= b_cnt + CNT_W'(1);
                        if (b_cnt == last) begin
                            state  <= md == 2'd2 ? RD : FIN;
                            k_cnt  <= '0;
                            d_k    <= '0;
                            d_j    <= '0;
                            out    <= '0;
                            a_addr <= base;
                            d_addr <= base;
                        end
                    end
                end
                RD: begin
                    if (!axi.arvalid && a_ok) begin
                        axi.arvalid <= 1'b1;
                        axi.araddr  <= a_addr;
                        axi.arid    <= k_cnt[ID_W-1:0];
                        a_addr      <= a_addr + strd;
                    end else if (ar_hs)
                        axi.arvalid <= 1'b0;
                    if (r_hs) begin
                        if (md == 2'd2 && axi.rdata != exp_d && err_cnt != 16'hFFFF)
                            err_cnt <= err_cnt + 16'd1;
                        // Burst boundaries come from rlast only; the beat count is never checked.
                        d_j <= axi.rlast ? 8'd0 : d_j + 8'd1;
                        if (axi.rlast) begin
                            d_k    <= d_k + CNT_W'(1);
                            d_addr <= d_addr + strd;
                            if (d_k == last)
                                state <= FIN;
                        end
                    end
                end
                FIN: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sal_axi_traffic_gen.sv
// tb_sal_axi_traffic_gen: scoreboard bench for sal_axi_traffic_gen with a memory-backed AXI slave
module tb_sal_axi_traffic_gen;
    localparam int ADDR_W = 32, DATA_W = 128, ID_W = 4, BL = 4, MAX_OUT = 4, CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic [1:0] mode = '0;
    logic [ADDR_W-1:0] base_addr = '0, stride = '0;
    logic [CNT_W-1:0] num_txn = '0;
    logic busy, done, resp_err;
    logic [15:0] err_cnt;

    sal_axi_traffic_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi();

    sal_axi_traffic_gen #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .BURST_LEN(BL), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
        .stride(stride), .num_txn(num_txn), .busy(busy), .done(done),
        .err_cnt(err_cnt), .resp_err(resp_err), .axi(axi)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event not expected or not seen", nm);
    endtask

    function automatic logic [DATA_W-1:0] pat(input int k, input int j, input logic [31:0] a);
        logic [31:0] w;
        w = {k[15:0], j[7:0], 8'hA5} ^ a;
        return {(DATA_W / 32){w}};
    endfunction

    // Slave model: always-ready address/data channels, memory echo, B queue, R served in AR order.
    logic [31:0] waq[$], raq[$];
    logic [1:0] bq[$];
    logic [DATA_W-1:0] mem [logic [31:0]];
    int wbeat = 0, rbeat = 0, r_total = 0, corrupt_at = -1, rerr_at = -1;
    bit b_hold = 0;
    logic [31:0] key;

    initial begin
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.arready = 0;
        axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
        forever begin
            @(posedge clk);
            #1;
            axi.awready = 1;
            axi.wready = 1;
            axi.arready = 1;
            axi.bvalid = bq.size() > 0 && !b_hold;
            axi.bresp = 2'b00;
            axi.rvalid = raq.size() > 0;
            axi.rlast = 1'b0;
            if (raq.size() > 0) begin
                key = raq[0] + 32'(rbeat);
                axi.rdata = (mem.exists(key) ? mem[key] : '0) ^ DATA_W'(r_total == corrupt_at);
                axi.rresp = r_total == rerr_at ? 2'b10 : 2'b00;
                axi.rlast = rbeat == BL - 1;
            end
            @(negedge clk);
            if (axi.awvalid && axi.awready) waq.push_back(axi.awaddr);
            if (axi.wvalid && axi.wready) begin
                mem[waq[0] + 32'(wbeat)] = axi.wdata;
                wbeat++;
                if (axi.wlast) begin
                    void'(waq.pop_front());
                    wbeat = 0;
                    bq.push_back(2'b00);
                end
            end
            if (axi.bvalid && axi.bready) void'(bq.pop_front());
            if (axi.rvalid && axi.rready) begin
                r_total++;
                if (axi.rlast) begin
                    void'(raq.pop_front());
                    rbeat = 0;
                end else rbeat++;
            end
            if (axi.arvalid && axi.arready) raq.push_back(axi.araddr);
        end
    end

    // Scoreboard queues filled by stimulus, drained by the monitor.
    logic [31:0] exp_aa[$], exp_ra[$];
    logic [ID_W-1:0] exp_ai[$], exp_ri[$];
    logic [DATA_W:0] exp_w[$];
    logic [16:0] exp_dn[$];
    logic [DATA_W:0] e_w;
    logic [16:0] e_d;
    int aw_n = 0, w_n = 0, wl_n = 0, b_n = 0, ar_n = 0, done_n = 0, dn_tgt = 0;
    logic [31:0] aw_first, aw_last;
    logic [DATA_W-1:0] w_first;

    initial forever begin
        @(negedge clk);
        if (axi.awvalid && axi.awready) begin
            aw_n++;
            if (aw_n == 1) aw_first = axi.awaddr;
            aw_last = axi.awaddr;
            if (exp_aa.size() == 0) fail("aw_unexpected");
            else begin
                chk("awaddr", axi.awaddr, exp_aa.pop_front());
                chk("awid", axi.awid, exp_ai.pop_front());
                chk("awlen", axi.awlen, 8'(BL - 1));
            end
        end
        if (axi.wvalid && axi.wready) begin
            w_n++;
            if (w_n == 1) w_first = axi.wdata;
            if (axi.wlast) wl_n++;
            if (exp_w.size() == 0) fail("w_unexpected");
            else begin
                e_w = exp_w.pop_front();
                chk("wdata", axi.wdata, e_w[DATA_W-1:0]);
                chk("wlast", axi.wlast, e_w[DATA_W]);
                chk("wstrb", axi.wstrb, 16'hFFFF);
            end
        end
        if (axi.bvalid && axi.bready) b_n++;
        if (axi.arvalid && axi.arready) begin
            ar_n++;
            if (exp_ra.size() == 0) fail("ar_unexpected");
            else begin
                chk("araddr", axi.araddr, exp_ra.pop_front());
                chk("arid", axi.arid, exp_ri.pop_front());
                chk("arlen", axi.arlen, 8'(BL - 1));
            end
        end
        if (done) begin
            done_n++;
            if (exp_dn.size() == 0) fail("done_unexpected");
            else begin
                e_d = exp_dn.pop_front();
                chk("err_cnt", err_cnt, e_d[15:0]);
                chk("resp_err", resp_err, e_d[16]);
                chk("busy_in_fin", busy, 1'b1);
            end
        end
    end

    task automatic clr_cnt();
        aw_n = 0; w_n = 0; wl_n = 0; b_n = 0; ar_n = 0;
    endtask

    // Called at posedge+1; start is sampled on the next rising edge.
    task automatic run(input logic [1:0] m, input logic [31:0] b, input logic [31:0] s, input int n,
                       input logic [15:0] e_err, input logic e_resp);
        clr_cnt();
        dn_tgt = done_n + 1;
        if (m != 2'd3)
            for (int k = 0; k < n; k++) begin
                logic [31:0] a;
                a = b + s * k;
                if (m != 2'd1) begin
                    exp_aa.push_back(a);
                    exp_ai.push_back(ID_W'(k));
                    for (int j = 0; j < BL; j++) exp_w.push_back({j == BL - 1, pat(k, j, a)});
                end
                if (m != 2'd0) begin
                    exp_ra.push_back(a);
                    exp_ri.push_back(ID_W'(k));
                end
            end
        exp_dn.push_back({e_resp, e_err});
        mode = m; base_addr = b; stride = s; num_txn = CNT_W'(n); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_n < dn_tgt && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (done_n < dn_tgt) fail("done_timeout");
    endtask

    task automatic after_run(input string tag);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, done_n, dn_tgt);
        chk({tag, "_idle"}, {busy, axi.bready, axi.rready}, 3'b000);
        chk({tag, "_sb_empty"}, exp_aa.size() + exp_w.size() + exp_ra.size() + exp_dn.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {busy, done, resp_err, axi.awvalid, axi.wvalid, axi.arvalid,
                             axi.bready, axi.rready, axi.wlast}, 9'h000);
        chk({tag, "_err_cnt"}, err_cnt, 16'h0);
        chk({tag, "_addr"}, {axi.awaddr, axi.araddr, axi.awid, axi.arid}, '0);
        chk({tag, "_wdata"}, axi.wdata, '0);
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b0;

        run(2'd0, 32'h1000, 32'h40, 3, 16'd0, 1'b0);
        wait_done();
        chk("t1_aw_n", aw_n, 3);
        chk("t1_w_beats", w_n, 12);
        chk("t1_wlast_n", wl_n, 3);
        chk("t1_aw_first", aw_first, 32'h1000);
        chk("t1_aw_last", aw_last, 32'h1080);
        chk("t1_w_first", w_first, {4{32'h000010A5}});
        after_run("t1");

        run(2'd2, 32'h2000, 32'h100, 8, 16'd0, 1'b0);
        wait_done();
        chk("t2_aw_n", aw_n, 8);
        chk("t2_ar_n", ar_n, 8);
        after_run("t2");

        b_hold = 1;
        run(2'd0, 32'h3000, 32'h40, 8, 16'd0, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        chk("t3_aw_before_b", aw_n, 4);
        chk("t3_b_held", b_n, 0);
        b_hold = 0;
        wait_done();
        chk("t3_aw_n", aw_n, 8);
        after_run("t3");

        corrupt_at = r_total + 5;
        run(2'd2, 32'h4000, 32'h40, 2, 16'd1, 1'b0);
        wait_done();
        corrupt_at = -1;
        after_run("t4a");

        rerr_at = r_total + 2;
        run(2'd2, 32'h4800, 32'h40, 2, 16'd0, 1'b1);
        wait_done();
        rerr_at = -1;
        after_run("t4b");

        run(2'd0, 32'hFFFF_FFC0, 32'h40, 2, 16'd0, 1'b0);
        wait_done();
        chk("t5_aw_n", aw_n, 2);
        chk("t5_wrap_addr", aw_last, 32'h0000_0000);
        after_run("t5");

        run(2'd3, 32'h7000, 32'h40, 5, 16'd0, 1'b0);
        wait_done();
        chk("t6_mode3_traffic", aw_n + ar_n, 0);
        after_run("t6");

        run(2'd2, 32'h7000, 32'h40, 0, 16'd0, 1'b0);
        wait_done();
        chk("t6_num0_traffic", aw_n + ar_n, 0);
        after_run("t6n");

        b_hold = 1;
        run(2'd0, 32'h5000, 32'h40, 4, 16'd0, 1'b0);
        t = 0;
        while (aw_n < 2 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (aw_n < 2) fail("t7_aw_timeout");
        rst_n = 1'b1;
        #1;
        chk_zero("t7_midrun");
        exp_aa.delete(); exp_ai.delete(); exp_w.delete(); exp_ra.delete(); exp_ri.delete(); exp_dn.delete();
        waq.delete(); raq.delete(); bq.delete();
        wbeat = 0; rbeat = 0; b_hold = 0;
        @(posedge clk);
        #1;
        chk_zero("t7_held");
        rst_n = 1'b0;
        run(2'd1, 32'h6000, 32'h40, 1, 16'd0, 1'b0);
        wait_done();
        chk("t7_ar_n", ar_n, 1);
        chk("t7_aw_n", aw_n, 0);
        after_run("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
